// File: rtl/riscv_bus_pkg.sv
`default_nettype none
// ============================================================================
// riscv_bus_pkg : shared types and address-map constants for the bus fabric
// Revision      : 1.0
// ============================================================================
package riscv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    localparam int          DEF_SEL_MSB  = 31;
    localparam int          DEF_SEL_LSB  = 24;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic [31:0] SLV0_BASE = 32'h0000_0000;
    localparam logic [31:0] SLV1_BASE = 32'h0100_0000;
    localparam logic [31:0] SLV2_BASE = 32'h0200_0000;
    localparam logic [31:0] SLV3_BASE = 32'h0300_0000;

    // Width of a slave index; at least one bit so a single-slave bus still has a port
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_bus_decoder.sv
`default_nettype none
// ============================================================================
// riscv_bus_decoder : address -> slave index plus mapped flag (combinational)
// Revision          : 1.0
// ============================================================================
module riscv_bus_decoder
    import riscv_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_MSB    = DEF_SEL_MSB,
    parameter int SEL_LSB    = DEF_SEL_LSB,
    parameter int IDX_W      = idx_width(NUM_SLAVES)
)(
    input  logic [31:0]      addr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [31:0] field;
    logic        unused_addr;

    assign field       = 32'(addr[SEL_MSB:SEL_LSB]);
    assign idx         = field[IDX_W-1:0];
    assign valid       = (field < 32'(NUM_SLAVES));
    assign unused_addr = ^addr;

endmodule
`default_nettype wire

// File: rtl/riscv_data_bus.sv
`default_nettype none
// ============================================================================
// riscv_data_bus : single-outstanding LSU-to-slaves interconnect with timeout
// Revision       : 1.0
// ============================================================================
module riscv_data_bus
    import riscv_bus_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter int          SEL_MSB    = DEF_SEL_MSB,
    parameter int          SEL_LSB    = DEF_SEL_LSB,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = DEF_ERR_DATA
)(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        m_req_i,
    input  logic                        m_we_i,
    input  logic [3:0]                  m_be_i,
    input  logic [31:0]                 m_addr_i,
    input  logic [31:0]                 m_wd_i,
    output logic [31:0]                 m_rd_o,
    output logic                        m_ready_o,
    output logic                        m_err_o,
    output logic [NUM_SLAVES-1:0]       s_req_o,
    output logic                        s_we_o,
    output logic [3:0]                  s_be_o,
    output logic [31:0]                 s_addr_o,
    output logic [31:0]                 s_wd_o,
    input  logic [NUM_SLAVES-1:0][31:0] s_rd_i,
    input  logic [NUM_SLAVES-1:0]       s_ready_i,
    output logic [7:0]                  err_cnt_o,
    output logic [31:0]                 err_addr_o
);

    localparam int             IDX_W    = idx_width(NUM_SLAVES);
    localparam int             CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_t       state, state_nxt;
    logic [IDX_W-1:0] dec_idx, sel;
    logic             dec_valid;
    logic [CNT_W-1:0] cnt;
    logic             sel_ready;
    logic             timeout_hit;

    riscv_bus_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_MSB    (SEL_MSB),
        .SEL_LSB    (SEL_LSB),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .addr  (m_addr_i),
        .idx   (dec_idx),
        .valid (dec_valid)
    );

    assign sel_ready   = s_ready_i[sel];
    assign timeout_hit = (cnt == CNT_LAST);
    assign m_ready_o   = (state == RESP);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_req_o   = '0;
        case (state)
            IDLE:    if (m_req_i) state_nxt = dec_valid ? ACCESS : RESP;
            ACCESS: begin
                s_req_o[sel] = 1'b1;
                if (sel_ready || timeout_hit) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sel        <= '0;
            cnt        <= '0;
            s_we_o     <= 1'b0;
            s_be_o     <= '0;
            s_addr_o   <= '0;
            s_wd_o     <= '0;
            m_rd_o     <= '0;
            m_err_o    <= 1'b0;
            err_cnt_o  <= '0;
            err_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req_i && dec_valid) begin
                        s_we_o   <= m_we_i;
                        s_be_o   <= m_be_i;
                        s_addr_o <= m_addr_i;
                        s_wd_o   <= m_wd_i;
                        sel      <= dec_idx;
                        cnt      <= '0;
                    end else if (m_req_i) begin
                        m_rd_o     <= ERR_DATA;
                        m_err_o    <= 1'b1;
                        err_addr_o <= m_addr_i;
                        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                    end
                end
                ACCESS: begin
                    // Ready is tested first so a last-cycle ready still succeeds
                    if (sel_ready) begin
                        m_rd_o  <= s_we_o ? 32'd0 : s_rd_i[sel];
                        m_err_o <= 1'b0;
                    end else if (timeout_hit) begin
                        m_rd_o     <= ERR_DATA;
                        m_err_o    <= 1'b1;
                        err_addr_o <= s_addr_o;
                        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_data_bus.sv
`default_nettype none
// ============================================================================
// tb_riscv_data_bus : scoreboard bench for riscv_data_bus
// Revision          : 1.0
// ============================================================================
module tb_riscv_data_bus;

    localparam int NS = 4;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                m_req_i, m_we_i;
    logic [3:0]          m_be_i;
    logic [31:0]         m_addr_i, m_wd_i;
    logic [31:0]         m_rd_o;
    logic                m_ready_o, m_err_o;
    logic [NS-1:0]       s_req_o;
    logic                s_we_o;
    logic [3:0]          s_be_o;
    logic [31:0]         s_addr_o, s_wd_o;
    logic [NS-1:0][31:0] s_rd_i;
    logic [NS-1:0]       s_ready_i;
    logic [7:0]          err_cnt_o;
    logic [31:0]         err_addr_o;

    riscv_data_bus #(
        .NUM_SLAVES (NS),
        .SEL_MSB    (31),
        .SEL_LSB    (24),
        .TIMEOUT    (16),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_be_i     (m_be_i),
        .m_addr_i   (m_addr_i),
        .m_wd_i     (m_wd_i),
        .m_rd_o     (m_rd_o),
        .m_ready_o  (m_ready_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_addr_o   (s_addr_o),
        .s_wd_o     (s_wd_o),
        .s_rd_i     (s_rd_i),
        .s_ready_i  (s_ready_i),
        .err_cnt_o  (err_cnt_o),
        .err_addr_o (err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // Slave model: slave i raises ready in its dly[i]-th request cycle (0 = never)
    int   dly [NS];
    int   held[NS];
    logic force3;

    always @(posedge clk_i) begin
        for (int i = 0; i < NS; i++) held[i] <= s_req_o[i] ? held[i] + 1 : 0;
    end

    always_comb begin
        for (int i = 0; i < NS; i++)
            s_ready_i[i] = (s_req_o[i] && dly[i] != 0 && held[i] + 1 >= dly[i])
                           || (i == 3 && force3);
    end

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction: push expectation, wait (bounded) for m_ready_o, pop and compare
    task automatic xfer(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int tgt, input int exp_hold);
        int            lat, hold, bad;
        bit            done;
        exp_t          e;
        logic [NS-1:0] one;
        one = 1;
        sb.push_back('{rd: exp_rd, err: exp_err});
        m_req_i = 1'b1; m_we_i = we; m_be_i = be; m_addr_i = addr; m_wd_i = wd;
        lat = 0; hold = 0; bad = 0; done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk_i);
            lat++;
            if (s_req_o != '0) begin
                if (tgt < 0 || s_req_o != (one << tgt)) bad++;
                else hold++;
                if (s_we_o != we || s_be_o != be || s_addr_o != addr || s_wd_o != wd) bad++;
            end
            if (m_ready_o) done = 1'b1;
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".rd"},  m_rd_o,         e.rd);
            check({tag, ".err"}, 32'(m_err_o),   32'(e.err));
        end
        check({tag, ".lat"},   32'(lat),  32'(exp_lat));
        check({tag, ".hold"},  32'(hold), 32'(exp_hold));
        check({tag, ".bcast"}, 32'(bad),  32'd0);
        m_req_i = 1'b0;
        @(negedge clk_i);
        check({tag, ".pulse"}, 32'(m_ready_o), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat, seen, first, gap, stray;
        exp_t e;

        rst_i = 1'b0; m_req_i = 1'b0; m_we_i = 1'b0; m_be_i = '0;
        m_addr_i = '0; m_wd_i = '0; force3 = 1'b0;
        s_rd_i = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0BAD_F00D};
        dly = '{0, 1, 5, 1};

        repeat (3) @(negedge clk_i);
        check("rst.ready",   32'(m_ready_o), 32'd0);
        check("rst.err",     32'(m_err_o),   32'd0);
        check("rst.rd",      m_rd_o,         32'd0);
        check("rst.sreq",    32'(s_req_o),   32'd0);
        check("rst.saddr",   s_addr_o,       32'd0);
        check("rst.errcnt",  32'(err_cnt_o), 32'd0);
        check("rst.erraddr", err_addr_o,     32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        xfer("rd1", 1'b0, 4'hF, 32'h0100_0010, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 1);
        xfer("wr2", 1'b1, 4'b0011, 32'h0200_0004, 32'hAABB_CCDD, 32'h0, 1'b0, 6, 2, 5);

        xfer("unmap", 1'b0, 4'hF, 32'h0700_0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, -1, 0);
        check("unmap.errcnt",  32'(err_cnt_o), 32'd1);
        check("unmap.erraddr", err_addr_o,     32'h0700_0000);
        check("unmap.hold_rd", m_rd_o,         32'hDEAD_BEEF);
        check("unmap.hold_er", 32'(m_err_o),   32'd1);

        xfer("tmo", 1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b1, 17, 0, 16);
        check("tmo.errcnt",  32'(err_cnt_o), 32'd2);
        check("tmo.erraddr", err_addr_o,     32'h0000_0040);

        // Ready arriving in the last allowed cycle must beat the timeout
        dly[2] = 16;
        xfer("lastcyc", 1'b0, 4'hF, 32'h0200_0008, 32'h0, 32'h2222_2222, 1'b0, 17, 2, 16);
        check("lastcyc.errcnt", 32'(err_cnt_o), 32'd2);
        dly[2] = 5;

        sb.push_back('{rd: 32'h1234_5678, err: 1'b0});
        sb.push_back('{rd: 32'h1234_5678, err: 1'b0});
        m_req_i = 1'b1; m_we_i = 1'b0; m_be_i = 4'hF; m_addr_i = 32'h0100_0020;
        lat = 0; seen = 0; first = 0; gap = 0;
        while (seen < 2 && lat < 50) begin
            @(negedge clk_i);
            lat++;
            if (m_ready_o) begin
                e = sb.pop_front();
                check("b2b.rd",  m_rd_o,       e.rd);
                check("b2b.err", 32'(m_err_o), 32'(e.err));
                seen++;
                if (seen == 1) first = lat;
                else           gap = lat - first;
            end
        end
        m_req_i = 1'b0;
        check("b2b.seen",  32'(seen),  32'd2);
        check("b2b.first", 32'(first), 32'd2);
        check("b2b.gap",   32'(gap),   32'd3);
        @(negedge clk_i);

        m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h0000_0080;
        repeat (3) @(negedge clk_i);
        check("rstmid.sreq_pre", 32'(s_req_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("rstmid.sreq",   32'(s_req_o),   32'd0);
        check("rstmid.ready",  32'(m_ready_o), 32'd0);
        check("rstmid.errcnt", 32'(err_cnt_o), 32'd0);
        m_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (m_ready_o) stray++;
        end
        check("rstmid.stray", 32'(stray), 32'd0);
        xfer("postrst", 1'b0, 4'hF, 32'h0100_0000, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 1);

        force3 = 1'b1;
        dly[0] = 3;
        xfer("ign3", 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 1'b0, 4, 0, 3);
        force3 = 1'b0;
        check("ign3.errcnt", 32'(err_cnt_o), 32'd0);

        for (int k = 0; k < 257; k++) begin
            xfer("sat", 1'b0, 4'hF, 32'h0400_0000 + 32'(k), 32'h0, 32'hDEAD_BEEF, 1'b1, 1, -1, 0);
            if (k == 253) check("sat.254", 32'(err_cnt_o), 32'd254);
        end
        check("sat.errcnt",  32'(err_cnt_o), 32'd255);
        check("sat.erraddr", err_addr_o,     32'h0400_0100);
        check("sb.empty",    32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
